// File: rtl/cnn_layer_sequencer.sv
// Sequencer that steps one CNN window per tile through fetch, conv, pool, activation and emit.
// Optional build macro CNN_SEQ_PERF_CNT_EN adds the saturating perf_cycles run-length counter.
module cnn_layer_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_TILES  = 16,
  parameter int STAGE_LAT  = 2,
  localparam int TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0]   in_weight,
  output logic [4*DATA_WIDTH-1:0] win_data,
  output logic [DATA_WIDTH-1:0]   win_weight,
  output logic                    conv_en,
  output logic                    pool_en,
  output logic                    act_en,
  input  logic [DATA_WIDTH-1:0]   act_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    busy,
  output logic                    done,
  output logic [TW-1:0]           tile_idx
`ifdef CNN_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]             perf_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CONV  = 3'd2,
    POOL  = 3'd3,
    ACT   = 3'd4,
    EMIT  = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [3:0]    LAST_CNT  = 4'(STAGE_LAT - 1);
  localparam logic [TW-1:0] LAST_TILE = TW'(NUM_TILES - 1);

  state_t     state_r, state_nxt;
  logic [3:0] cnt_r, cnt_nxt;
  logic       stage_last_s;
  logic       start_take_s;
  logic       fetch_hs_s;
  logic       emit_hs_s;

  assign stage_last_s = (cnt_r == LAST_CNT);
  assign start_take_s = (state_r == IDLE) && start;
  assign fetch_hs_s   = in_valid && in_ready;
  assign emit_hs_s    = (state_r == EMIT) && out_ready;

  // State and stage-cycle counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
    end
  end

  // Next-state logic; each datapath stage is held for STAGE_LAT cycles
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt = FETCH;
        else       state_nxt = IDLE;
        cnt_nxt = 4'd0;
      end
      FETCH: begin
        if (fetch_hs_s) state_nxt = CONV;
        else            state_nxt = FETCH;
        cnt_nxt = 4'd0;
      end
      CONV, POOL, ACT: begin
        if (stage_last_s) begin
          cnt_nxt = 4'd0;
          if (state_r == CONV)      state_nxt = POOL;
          else if (state_r == POOL) state_nxt = ACT;
          else                      state_nxt = EMIT;
        end else begin
          cnt_nxt = cnt_r + 4'd1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (tile_idx == LAST_TILE) state_nxt = DONE;
          else                       state_nxt = FETCH;
        end else begin
          state_nxt = EMIT;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Registered outputs, decoded from the upcoming state so they align with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready   <= 1'b0;
      conv_en    <= 1'b0;
      pool_en    <= 1'b0;
      act_en     <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tile_idx   <= '0;
      win_data   <= '0;
      win_weight <= '0;
      out_data   <= '0;
    end else begin
      in_ready  <= (state_nxt == FETCH);
      conv_en   <= (state_nxt == CONV);
      pool_en   <= (state_nxt == POOL);
      act_en    <= (state_nxt == ACT);
      out_valid <= (state_nxt == EMIT);
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
      if (start_take_s) begin
        tile_idx <= '0;
      end else if (emit_hs_s && (tile_idx != LAST_TILE)) begin
        tile_idx <= tile_idx + TW'(1);
      end else begin
        tile_idx <= tile_idx;
      end
      if (fetch_hs_s) begin
        win_data   <= in_data;
        win_weight <= in_weight;
      end
      if ((state_r == ACT) && stage_last_s) begin
        out_data <= act_result;
      end
    end
  end

`ifdef CNN_SEQ_PERF_CNT_EN
  // Run-length counter: cleared on an accepted start, saturates at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles <= 32'd0;
    end else if (start_take_s) begin
      perf_cycles <= 32'd0;
    end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end else begin
      perf_cycles <= perf_cycles;
    end
  end
`else
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed table-driven bench for cnn_layer_sequencer with NUM_TILES=2, STAGE_LAT=2.
module tb_cnn_layer_sequencer;

  localparam logic [31:0] D0 = 32'h1122_3344;
  localparam logic [31:0] D1 = 32'hA1B2_C3D4;
  localparam logic [31:0] XX = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_weight;
  logic [31:0] win_data;
  logic [7:0]  win_weight;
  logic        conv_en;
  logic        pool_en;
  logic        act_en;
  logic [7:0]  act_result;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic        done;
  logic [0:0]  tile_idx;
`ifdef CNN_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  int checks = 0;
  int errors = 0;

  cnn_layer_sequencer #(.DATA_WIDTH(8), .NUM_TILES(2), .STAGE_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
    .win_data(win_data), .win_weight(win_weight),
    .conv_en(conv_en), .pool_en(pool_en), .act_en(act_en),
    .act_result(act_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .tile_idx(tile_idx)
`ifdef CNN_SEQ_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags order: {in_ready, conv_en, pool_en, act_en, out_valid, busy, done}
  typedef struct packed {
    logic        start;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic [7:0]  in_weight;
    logic [7:0]  act_result;
    logic [6:0]  flags;
    logic        tile;
    logic [7:0]  out_data;
    logic [31:0] win_data;
    logic [7:0]  win_weight;
  } vec_t;

  vec_t vecs [19];

  function automatic logic [6:0] flags_now();
    return {in_ready, conv_en, pool_en, act_en, out_valid, busy, done};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // row k: inputs applied before edge k, outputs expected after edge k
    vecs[0]  = '{1'b1, 1'b1, 1'b1, D0, 8'h5A, 8'h00, 7'b1000010, 1'b0, 8'h00, 32'h0, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, D0, 8'h5A, 8'h00, 7'b0100010, 1'b0, 8'h00, D0, 8'h5A};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, XX, 8'hFF, 8'h00, 7'b0100010, 1'b0, 8'h00, D0, 8'h5A};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, XX, 8'hFF, 8'h00, 7'b0010010, 1'b0, 8'h00, D0, 8'h5A};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, XX, 8'hFF, 8'h00, 7'b0010010, 1'b0, 8'h00, D0, 8'h5A};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, XX, 8'hFF, 8'h00, 7'b0001010, 1'b0, 8'h00, D0, 8'h5A};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, XX, 8'hFF, 8'hFF, 7'b0001010, 1'b0, 8'h00, D0, 8'h5A};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, XX, 8'hFF, 8'h5E, 7'b0000110, 1'b0, 8'h5E, D0, 8'h5A};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, D1, 8'h3C, 8'h11, 7'b1000010, 1'b1, 8'h5E, D0, 8'h5A};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, D1, 8'h3C, 8'h11, 7'b0100010, 1'b1, 8'h5E, D1, 8'h3C};
    vecs[10] = '{1'b0, 1'b1, 1'b1, XX, 8'hFF, 8'h11, 7'b0100010, 1'b1, 8'h5E, D1, 8'h3C};
    vecs[11] = '{1'b0, 1'b1, 1'b1, XX, 8'hFF, 8'h11, 7'b0010010, 1'b1, 8'h5E, D1, 8'h3C};
    vecs[12] = '{1'b0, 1'b1, 1'b1, XX, 8'hFF, 8'h11, 7'b0010010, 1'b1, 8'h5E, D1, 8'h3C};
    vecs[13] = '{1'b0, 1'b1, 1'b1, XX, 8'hFF, 8'h11, 7'b0001010, 1'b1, 8'h5E, D1, 8'h3C};
    vecs[14] = '{1'b0, 1'b1, 1'b1, XX, 8'hFF, 8'h11, 7'b0001010, 1'b1, 8'h5E, D1, 8'h3C};
    vecs[15] = '{1'b0, 1'b1, 1'b1, XX, 8'hFF, 8'hC3, 7'b0000110, 1'b1, 8'hC3, D1, 8'h3C};
    vecs[16] = '{1'b0, 1'b1, 1'b1, XX, 8'hFF, 8'h00, 7'b0000011, 1'b1, 8'hC3, D1, 8'h3C};
    vecs[17] = '{1'b0, 1'b1, 1'b1, XX, 8'hFF, 8'h00, 7'b0000000, 1'b1, 8'hC3, D1, 8'h3C};
    vecs[18] = '{1'b0, 1'b1, 1'b1, XX, 8'hFF, 8'h00, 7'b0000000, 1'b1, 8'hC3, D1, 8'h3C};

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 32'h0; in_weight = 8'h00; act_result = 8'h00;
    step();
    step();
    chk("reset_flags", 64'(flags_now()), 64'(7'b0000000));
    chk("reset_tile", 64'(tile_idx), 64'd0);
    chk("reset_data", {out_data, win_weight, win_data}, 64'd0);
    rst = 1'b1;
    step();

    // Two-tile run with zero-wait handshakes and a start pulse during CONV
    for (int k = 0; k < 19; k++) begin
      start      = vecs[k].start;
      in_valid   = vecs[k].in_valid;
      out_ready  = vecs[k].out_ready;
      in_data    = vecs[k].in_data;
      in_weight  = vecs[k].in_weight;
      act_result = vecs[k].act_result;
      step();
      chk($sformatf("row%0d_flags", k), 64'(flags_now()), 64'(vecs[k].flags));
      chk($sformatf("row%0d_tile", k), 64'(tile_idx), 64'(vecs[k].tile));
      chk($sformatf("row%0d_out_data", k), 64'(out_data), 64'(vecs[k].out_data));
      chk($sformatf("row%0d_win_data", k), 64'(win_data), 64'(vecs[k].win_data));
      chk($sformatf("row%0d_win_weight", k), 64'(win_weight), 64'(vecs[k].win_weight));
`ifdef CNN_SEQ_PERF_CNT_EN
      chk($sformatf("row%0d_perf", k), 64'(perf_cycles), 64'((k < 17) ? k : 17));
`endif
    end

    // FETCH stall of five cycles
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1; act_result = 8'h00;
    step();
    start = 1'b0;
    chk("stall_tile0", 64'(tile_idx), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stall%0d_flags", i), 64'(flags_now()), 64'(7'b1000010));
    end
    in_valid = 1'b1; in_data = 32'h0BAD_F00D; in_weight = 8'h77;
    step();
    chk("resume_flags", 64'(flags_now()), 64'(7'b0100010));
    chk("resume_win", {24'd0, win_weight, win_data}, {24'd0, 8'h77, 32'h0BAD_F00D});

    // EMIT backpressure with act_result changing while stalled
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("last_act_flags", 64'(flags_now()), 64'(7'b0001010));
    act_result = 8'hA5;
    step();
    act_result = 8'h3F;
    chk("emit_out_data", 64'(out_data), 64'h A5);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("hold%0d_flags", i), 64'(flags_now()), 64'(7'b0000110));
      chk($sformatf("hold%0d_out_data", i), 64'(out_data), 64'hA5);
    end
    out_ready = 1'b1;
    step();
    chk("after_hs_flags", 64'(flags_now()), 64'(7'b1000010));
    chk("after_hs_tile", 64'(tile_idx), 64'd1);
    chk("after_hs_out_data", 64'(out_data), 64'hA5);

    // Reset during POOL of tile 1
    step();
    step();
    step();
    chk("pre_rst_flags", 64'(flags_now()), 64'(7'b0010010));
    rst = 1'b0;
    #1;
    chk("rst_flags", 64'(flags_now()), 64'(7'b0000000));
    chk("rst_tile", 64'(tile_idx), 64'd0);
    chk("rst_data", {out_data, win_weight, win_data}, 64'd0);
`ifdef CNN_SEQ_PERF_CNT_EN
    chk("rst_perf", 64'(perf_cycles), 64'd0);
`endif
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst%0d_flags", i), 64'(flags_now()), 64'(7'b0000000));
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_flags", 64'(flags_now()), 64'(7'b1000010));
    chk("restart_tile", 64'(tile_idx), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
